fetch_prefetch_unit: RTL
========================

Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the bare PC register plus combinational branch/jump muxing of the single-cycle datapath. It owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates wait states. Returned words go into a DEPTH-entry prefetch FIFO, and the FIFO presents instructions with their PC to the decode/execute stage over a valid/ready interface. Branch and jump targets are resolved internally; a redirect flushes the FIFO and discards any in-flight response.

Parameters:
PC_WIDTH, 10, width of PC and instruction-memory byte address; all PC arithmetic is modulo 2^PC_WIDTH
RESET_PC, 0, PC loaded on reset; must be word-aligned
FIFO_DEPTH, 4, prefetch entries; power of two and >= 2
INSTR_WIDTH, 32, instruction word width

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
imem_req  out  1  request valid; held with imem_addr stable until imem_ack
imem_addr  out  PC_WIDTH  request byte address
imem_ack  in  1  response valid this cycle; only meaningful while imem_req=1
imem_rdata  in  INSTR_WIDTH  response word, sampled when imem_req&imem_ack
instr_valid  out  1  FIFO head valid (count != 0)
instr  out  INSTR_WIDTH  head instruction; 0 when instr_valid=0
instr_pc  out  PC_WIDTH  PC of head instruction; 0 when instr_valid=0
instr_ready  in  1  consumer accepts head when instr_valid&instr_ready
branch  in  1  executing instruction is a conditional branch
zero  in  1  ALU zero flag; branch is taken when branch&zero
jump  in  1  executing instruction is a jump; has priority over branch
redir_pc  in  PC_WIDTH  PC of the branch/jump instruction
branch_imm  in  16  instr[15:0] branch offset in words
jump_index  in  26  instr[25:0] jump index

Behaviour:
- Reset (async assert, sync-free release): fetch_pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, state=IDLE, FIFO count/pointers=0, instr_valid=0, instr=0, instr_pc=0. FIFO storage is not reset.
- Target arithmetic, with p4 = redir_pc+4:
  - Branch target = p4 + (sign_extend(branch_imm)<<2), truncated to PC_WIDTH.
  - Jump target = {p4 bits above 27 if PC_WIDTH>28, jump_index<<2}, truncated to PC_WIDTH.
- Redirect:
  - A redirect occurs when jump=1, or branch=1 and zero=1. branch=1 with zero=0 has no effect.
  - On redirect: FIFO flushed (count=0) and fetch_pc=target at the same edge.
- space = (FIFO_DEPTH - count_after_this_edge) > 0, where count_after includes the push and pop of the same cycle.
- State IDLE (imem_req=0):
  - If space or redirect: go to REQ; imem_addr = fetch_pc (or target on redirect).
- State REQ (imem_req=1):
  - On ack without redirect: push {imem_rdata, imem_addr}; fetch_pc+=4. Stay in REQ with imem_addr=new fetch_pc if space, else go to IDLE.
  - On ack with redirect: discard the response. Stay in REQ with imem_addr=target.
  - Redirect without ack: go to DRAIN; imem_addr unchanged.
- State DRAIN (imem_req=1, old imem_addr held):
  - On ack: discard the response; go to REQ with imem_addr=fetch_pc.
  - A further redirect in DRAIN updates fetch_pc only.
- Throughput and latency:
  - At most one outstanding request.
  - Zero-wait memory (ack same cycle as req): one push per cycle.
  - An instruction appears on instr the cycle after its ack edge.
- FIFO:
  - Show-ahead: instr/instr_pc are driven from the head entry.
  - Push and pop in the same cycle is legal, including when full (pop frees the slot, count unchanged).
  - Pop when empty is ignored. Pointers wrap mod FIFO_DEPTH.
- Redirect vs. consumer:
  - A redirect in the same cycle as a pop: the pop completes and the flush still clears all remaining entries.
  - No word fetched before a redirect ever reaches instr after it.
- PC wrap: fetch_pc+4 wraps modulo 2^PC_WIDTH with no error.

Test Plan:
- Reset, zero-wait memory, instr_ready=1 -> imem_req rises on the 1st edge after release; imem_addr 0,4,8,...; instr_valid one cycle after the first ack; instr_pc follows 0,4,8.
- instr_ready=0, FIFO_DEPTH=4, zero-wait -> exactly 4 acks (addr 0..12), then imem_req=0 with count=4 and instr_pc=0. Then instr_ready=1 -> next request at addr 16; pops yield PCs 0,4,8,12,16 in order.
- Branch taken: redir_pc=8, branch_imm=16'hFFFE, zero=1 -> FIFO emptied next cycle; next imem_addr=4. Same stimulus with zero=0 -> no flush, fetch order unchanged.
- Jump with a 3-cycle-wait request outstanding at addr 20, jump_index=26'h40 -> DRAIN; old ack discarded; next imem_addr=0x100; no instr_pc=20 is ever presented.
- Wrap: PC_WIDTH=10, fetch_pc=0x3FC -> the request after 0x3FC is 0x000, and instr_pc sequence shows 0x3FC then 0x000.
- reset_n asserted mid-REQ (imem_req=1, count=2) -> imem_req=0, instr_valid=0, imem_addr=RESET_PC immediately, without a clock edge; normal fetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack handshake into a
// show-ahead prefetch FIFO, and resolves branch/jump redirects internally.
module fetch_prefetch_unit #(
    parameter int unsigned         PC_WIDTH    = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         FIFO_DEPTH  = 4,
    parameter int unsigned         INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_ready,
    input  logic                   branch,
    input  logic                   zero,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    redir_pc,
    input  logic [15:0]            branch_imm,
    input  logic [25:0]            jump_index
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW    = (PC_WIDTH > 32) ? PC_WIDTH : 32;

    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);
    localparam logic [AW-1:0]       HI_MASK  = ~AW'(28'hFFF_FFFF);

    typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;

    logic [INSTR_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem   [FIFO_DEPTH];

    logic                redirect;
    logic                push;
    logic                pop;
    logic                space;
    logic [PC_WIDTH-1:0] p4;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] jmp_target;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_next;

    // Target arithmetic is done modulo 2^PC_WIDTH; the signed cast sign-extends or truncates.
    assign p4         = redir_pc + PC_STEP;
    assign br_target  = p4 + PC_WIDTH'($signed({branch_imm, 2'b00}));
    assign jmp_target = PC_WIDTH'((AW'(p4) & HI_MASK) | AW'({jump_index, 2'b00}));
    assign target     = jump ? jmp_target : br_target;
    assign redirect   = jump | (branch & zero);
    assign pc_next    = fetch_pc_q + PC_STEP;

    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : '0;
    assign imem_req    = (state_q != StIdle);
    assign imem_addr   = addr_q;

    assign push = (state_q == StReq) && imem_ack && !redirect;
    assign pop  = instr_valid && instr_ready;

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    assign space = (count_d != CNT_FULL);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    state_d    = StReq;
                    fetch_pc_d = target;
                    addr_d     = target;
                end else if (space) begin
                    state_d = StReq;
                    addr_d  = fetch_pc_q;
                end
            end
            StReq: begin
                if (imem_ack && !redirect) begin
                    fetch_pc_d = pc_next;
                    addr_d     = pc_next;
                    state_d    = space ? StReq : StIdle;
                end else if (redirect) begin
                    fetch_pc_d = target;
                    // Without an ack the old request must complete before a new one issues.
                    if (imem_ack) begin
                        addr_d = target;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end
                if (imem_ack) begin
                    state_d = StReq;
                    addr_d  = redirect ? target : fetch_pc_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

endmodule
